// File: rtl/rob_pkg.sv
// Shared constants and tag/index helpers for the parametrised reorder buffer.
package rob_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int XLEN_DEF  = 32;
    localparam int RA_W_DEF  = 5;

    // Tag 0 means "operand has no in-flight producer".
    localparam int TAG_NONE  = 0;

    // Tags run 1..DEPTH, so the width must hold DEPTH itself.
    function automatic int tag_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int tag_to_idx(input int tag);
        return tag - 1;
    endfunction

    function automatic int idx_to_tag(input int idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/rob_operand_port.sv
// One operand lookup: stored entry value, or the value being written back this cycle.
module rob_operand_port
    import rob_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = tag_w(DEPTH)
) (
    input  logic [TAG_W-1:0]      tag_i,
    input  logic [DEPTH-1:0]      ent_ready_i,
    input  logic [DEPTH*XLEN-1:0] ent_data_i,
    input  logic                  alu_valid_i,
    input  logic [TAG_W-1:0]      alu_tag_i,
    input  logic [XLEN-1:0]       alu_result_i,
    input  logic                  lsu_valid_i,
    input  logic [TAG_W-1:0]      lsu_tag_i,
    input  logic [XLEN-1:0]       lsu_result_i,
    output logic                  ready_o,
    output logic [XLEN-1:0]       data_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] TAG_MAX = TAG_W'(DEPTH);

    logic [IDX_W-1:0] idx;
    assign idx = IDX_W'(tag_to_idx(int'(tag_i)));

    // Bypass priority: LSU bus, then ALU bus, then the stored entry.
    always_comb begin
        ready_o = 1'b0;
        data_o  = '0;
        if (tag_i != TAG_W'(TAG_NONE) && tag_i <= TAG_MAX) begin
            if (lsu_valid_i && lsu_tag_i == tag_i) begin
                ready_o = 1'b1;
                data_o  = lsu_result_i;
            end else if (alu_valid_i && alu_tag_i == tag_i) begin
                ready_o = 1'b1;
                data_o  = alu_result_i;
            end else if (ent_ready_i[idx]) begin
                ready_o = 1'b1;
                data_o  = ent_data_i[idx*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/rob_param_core.sv
// In-order-commit reorder buffer: allocation, writeback capture, commit and mispredict flush.
module rob_param_core
    import rob_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int XLEN  = XLEN_DEF,
    parameter int RA_W  = RA_W_DEF,
    parameter int TAG_W = tag_w(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             disp_valid_in,
    output logic             disp_ready_out,
    output logic [TAG_W-1:0] disp_tag_out,
    input  logic [RA_W-1:0]  disp_rd_in,
    input  logic [XLEN-1:0]  disp_pc_in,
    input  logic [XLEN-1:0]  disp_fall_pc_in,
    input  logic             disp_is_br_in,
    input  logic             disp_is_st_in,
    input  logic             disp_pred_tk_in,
    input  logic [TAG_W-1:0] q1_tag_in,
    input  logic [TAG_W-1:0] q2_tag_in,
    output logic             q1_ready_out,
    output logic             q2_ready_out,
    output logic [XLEN-1:0]  q1_data_out,
    output logic [XLEN-1:0]  q2_data_out,
    input  logic             alu_valid_in,
    input  logic [TAG_W-1:0] alu_tag_in,
    input  logic [XLEN-1:0]  alu_result_in,
    input  logic             alu_taken_in,
    input  logic [XLEN-1:0]  alu_target_in,
    input  logic             lsu_valid_in,
    input  logic [TAG_W-1:0] lsu_tag_in,
    input  logic [XLEN-1:0]  lsu_result_in,
    input  logic             st_ready_in,
    output logic             commit_valid_out,
    output logic [TAG_W-1:0] commit_tag_out,
    output logic [RA_W-1:0]  commit_rd_out,
    output logic [XLEN-1:0]  commit_data_out,
    output logic             commit_st_out,
    output logic             flush_out,
    output logic [XLEN-1:0]  flush_pc_out,
    output logic             bp_upd_out,
    output logic [XLEN-1:0]  bp_pc_out,
    output logic             bp_taken_out,
    output logic [TAG_W-1:0] count_out,
    output logic             empty_out
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] TAG_MAX = TAG_W'(DEPTH);

    // Control state (reset)
    logic [IDX_W-1:0] head_q, tail_q;
    logic [TAG_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] ent_valid_q, ent_ready_q;
    logic             commit_valid_q, commit_st_q, flush_q, bp_upd_q, bp_taken_q;
    logic [TAG_W-1:0] commit_tag_q;
    logic [RA_W-1:0]  commit_rd_q;
    logic [XLEN-1:0]  commit_data_q, flush_pc_q, bp_pc_q;

    // Entry payload (not reset; only meaningful while the entry is valid)
    logic [XLEN-1:0]  ent_data_q [DEPTH];
    logic [XLEN-1:0]  ent_pc_q [DEPTH];
    logic [XLEN-1:0]  ent_fall_q [DEPTH];
    logic [XLEN-1:0]  ent_target_q [DEPTH];
    logic [RA_W-1:0]  ent_rd_q [DEPTH];
    logic [DEPTH-1:0] ent_br_q, ent_st_q, ent_pred_q, ent_taken_q;

    logic [IDX_W-1:0]      alu_idx, lsu_idx;
    logic                  alu_hit, lsu_hit, alloc_en, commit_en, head_ok, mispredict;
    logic [DEPTH*XLEN-1:0] ent_data_flat;

    assign alu_idx = IDX_W'(tag_to_idx(int'(alu_tag_in)));
    assign lsu_idx = IDX_W'(tag_to_idx(int'(lsu_tag_in)));

    // Writebacks are captured only for a live entry, and never during flush or stall.
    assign alu_hit = rdy_in && !flush_q && alu_valid_in && alu_tag_in != TAG_W'(TAG_NONE)
                     && alu_tag_in <= TAG_MAX && ent_valid_q[alu_idx];
    assign lsu_hit = rdy_in && !flush_q && lsu_valid_in && lsu_tag_in != TAG_W'(TAG_NONE)
                     && lsu_tag_in <= TAG_MAX && ent_valid_q[lsu_idx];

    // Full blocks allocation even when the head retires in the same cycle.
    assign disp_ready_out = (count_q < TAG_MAX) && !flush_q;
    assign disp_tag_out   = TAG_W'(idx_to_tag(int'(tail_q)));
    assign alloc_en       = rdy_in && disp_valid_in && disp_ready_out;

    // A store may retire before its ROB entry is marked ready once the LSB has it resolved.
    assign head_ok    = ent_valid_q[head_q] && !flush_q &&
                        (ent_ready_q[head_q] || (ent_st_q[head_q] && st_ready_in));
    assign commit_en  = rdy_in && head_ok;
    assign mispredict = ent_br_q[head_q] && (ent_taken_q[head_q] != ent_pred_q[head_q]);

    // Occupancy tracks alloc minus commit; simultaneous alloc and commit cancel out.
    always_comb begin
        count_d = count_q;
        if (alloc_en && !commit_en)
            count_d = count_q + 1'b1;
        else if (commit_en && !alloc_en)
            count_d = count_q - 1'b1;
    end

    // Flatten stored values for the operand lookup ports.
    always_comb begin
        ent_data_flat = '0;
        for (int i = 0; i < DEPTH; i++)
            ent_data_flat[i*XLEN +: XLEN] = ent_data_q[i];
    end

    // Pointers, entry status flags and registered commit/flush/predictor outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            ent_valid_q    <= '0;
            ent_ready_q    <= '0;
            commit_valid_q <= 1'b0;
            commit_tag_q   <= '0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
            commit_st_q    <= 1'b0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
            bp_upd_q       <= 1'b0;
            bp_pc_q        <= '0;
            bp_taken_q     <= 1'b0;
        end else if (rdy_in) begin
            if (flush_q) begin
                head_q         <= '0;
                tail_q         <= '0;
                count_q        <= '0;
                ent_valid_q    <= '0;
                ent_ready_q    <= '0;
                flush_q        <= 1'b0;
                commit_valid_q <= 1'b0;
                bp_upd_q       <= 1'b0;
            end else begin
                count_q        <= count_d;
                commit_valid_q <= commit_en;
                bp_upd_q       <= 1'b0;
                if (alloc_en) begin
                    ent_valid_q[tail_q] <= 1'b1;
                    ent_ready_q[tail_q] <= 1'b0;
                    tail_q              <= tail_q + 1'b1;
                end
                if (alu_hit)
                    ent_ready_q[alu_idx] <= 1'b1;
                if (lsu_hit)
                    ent_ready_q[lsu_idx] <= 1'b1;
                if (commit_en) begin
                    ent_valid_q[head_q] <= 1'b0;
                    head_q              <= head_q + 1'b1;
                    commit_tag_q        <= TAG_W'(idx_to_tag(int'(head_q)));
                    commit_rd_q         <= ent_rd_q[head_q];
                    commit_data_q       <= ent_data_q[head_q];
                    commit_st_q         <= ent_st_q[head_q];
                    if (ent_br_q[head_q]) begin
                        bp_upd_q   <= 1'b1;
                        bp_pc_q    <= ent_pc_q[head_q];
                        bp_taken_q <= ent_taken_q[head_q];
                        if (mispredict) begin
                            flush_q    <= 1'b1;
                            flush_pc_q <= ent_taken_q[head_q] ? ent_target_q[head_q]
                                                              : ent_fall_q[head_q];
                        end
                    end
                end
            end
        end
    end

    // Entry payload: captured at allocation, then overwritten by writeback (LSU after ALU).
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_q) begin
            if (alloc_en) begin
                ent_data_q[tail_q] <= '0;
                ent_rd_q[tail_q]   <= disp_rd_in;
                ent_pc_q[tail_q]   <= disp_pc_in;
                ent_fall_q[tail_q] <= disp_fall_pc_in;
                ent_br_q[tail_q]   <= disp_is_br_in;
                ent_st_q[tail_q]   <= disp_is_st_in;
                ent_pred_q[tail_q] <= disp_pred_tk_in;
            end
            if (alu_hit) begin
                ent_data_q[alu_idx]   <= alu_result_in;
                ent_taken_q[alu_idx]  <= alu_taken_in;
                ent_target_q[alu_idx] <= alu_target_in;
            end
            if (lsu_hit)
                ent_data_q[lsu_idx] <= lsu_result_in;
        end
    end

    // Two writeback ports naming the same entry in one cycle is an upstream bug.
    assert property (@(posedge clk_in) disable iff (!rst_n_in)
        !(rdy_in && alu_valid_in && lsu_valid_in && alu_tag_in == lsu_tag_in &&
          alu_tag_in != TAG_W'(TAG_NONE)));

    rob_operand_port #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) u_q1 (
        .tag_i        (q1_tag_in),
        .ent_ready_i  (ent_ready_q),
        .ent_data_i   (ent_data_flat),
        .alu_valid_i  (alu_valid_in),
        .alu_tag_i    (alu_tag_in),
        .alu_result_i (alu_result_in),
        .lsu_valid_i  (lsu_valid_in),
        .lsu_tag_i    (lsu_tag_in),
        .lsu_result_i (lsu_result_in),
        .ready_o      (q1_ready_out),
        .data_o       (q1_data_out)
    );

    rob_operand_port #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W)) u_q2 (
        .tag_i        (q2_tag_in),
        .ent_ready_i  (ent_ready_q),
        .ent_data_i   (ent_data_flat),
        .alu_valid_i  (alu_valid_in),
        .alu_tag_i    (alu_tag_in),
        .alu_result_i (alu_result_in),
        .lsu_valid_i  (lsu_valid_in),
        .lsu_tag_i    (lsu_tag_in),
        .lsu_result_i (lsu_result_in),
        .ready_o      (q2_ready_out),
        .data_o       (q2_data_out)
    );

    assign commit_valid_out = commit_valid_q;
    assign commit_tag_out   = commit_tag_q;
    assign commit_rd_out    = commit_rd_q;
    assign commit_data_out  = commit_data_q;
    assign commit_st_out    = commit_st_q;
    assign flush_out        = flush_q;
    assign flush_pc_out     = flush_pc_q;
    assign bp_upd_out       = bp_upd_q;
    assign bp_pc_out        = bp_pc_q;
    assign bp_taken_out     = bp_taken_q;
    assign count_out        = count_q;
    assign empty_out        = (count_q == '0);

endmodule

// File: tb/tb_rob_param_core.sv
// Directed bench for rob_param_core with a 4-entry buffer.
module tb_rob_param_core;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int RA_W  = 5;
    localparam int TAG_W = 3;

    logic             clk_in = 1'b0;
    logic             rst_n_in = 1'b0;
    logic             rdy_in = 1'b1;
    logic             disp_valid_in = 1'b0;
    logic             disp_ready_out;
    logic [TAG_W-1:0] disp_tag_out;
    logic [RA_W-1:0]  disp_rd_in = '0;
    logic [XLEN-1:0]  disp_pc_in = '0;
    logic [XLEN-1:0]  disp_fall_pc_in = '0;
    logic             disp_is_br_in = 1'b0;
    logic             disp_is_st_in = 1'b0;
    logic             disp_pred_tk_in = 1'b0;
    logic [TAG_W-1:0] q1_tag_in = '0;
    logic [TAG_W-1:0] q2_tag_in = '0;
    logic             q1_ready_out, q2_ready_out;
    logic [XLEN-1:0]  q1_data_out, q2_data_out;
    logic             alu_valid_in = 1'b0;
    logic [TAG_W-1:0] alu_tag_in = '0;
    logic [XLEN-1:0]  alu_result_in = '0;
    logic             alu_taken_in = 1'b0;
    logic [XLEN-1:0]  alu_target_in = '0;
    logic             lsu_valid_in = 1'b0;
    logic [TAG_W-1:0] lsu_tag_in = '0;
    logic [XLEN-1:0]  lsu_result_in = '0;
    logic             st_ready_in = 1'b0;
    logic             commit_valid_out;
    logic [TAG_W-1:0] commit_tag_out;
    logic [RA_W-1:0]  commit_rd_out;
    logic [XLEN-1:0]  commit_data_out;
    logic             commit_st_out;
    logic             flush_out;
    logic [XLEN-1:0]  flush_pc_out;
    logic             bp_upd_out;
    logic [XLEN-1:0]  bp_pc_out;
    logic             bp_taken_out;
    logic [TAG_W-1:0] count_out;
    logic             empty_out;

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    rob_param_core #(.DEPTH(DEPTH), .XLEN(XLEN), .RA_W(RA_W)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .disp_valid_in(disp_valid_in), .disp_ready_out(disp_ready_out),
        .disp_tag_out(disp_tag_out), .disp_rd_in(disp_rd_in), .disp_pc_in(disp_pc_in),
        .disp_fall_pc_in(disp_fall_pc_in), .disp_is_br_in(disp_is_br_in),
        .disp_is_st_in(disp_is_st_in), .disp_pred_tk_in(disp_pred_tk_in),
        .q1_tag_in(q1_tag_in), .q2_tag_in(q2_tag_in),
        .q1_ready_out(q1_ready_out), .q2_ready_out(q2_ready_out),
        .q1_data_out(q1_data_out), .q2_data_out(q2_data_out),
        .alu_valid_in(alu_valid_in), .alu_tag_in(alu_tag_in), .alu_result_in(alu_result_in),
        .alu_taken_in(alu_taken_in), .alu_target_in(alu_target_in),
        .lsu_valid_in(lsu_valid_in), .lsu_tag_in(lsu_tag_in), .lsu_result_in(lsu_result_in),
        .st_ready_in(st_ready_in),
        .commit_valid_out(commit_valid_out), .commit_tag_out(commit_tag_out),
        .commit_rd_out(commit_rd_out), .commit_data_out(commit_data_out),
        .commit_st_out(commit_st_out), .flush_out(flush_out), .flush_pc_out(flush_pc_out),
        .bp_upd_out(bp_upd_out), .bp_pc_out(bp_pc_out), .bp_taken_out(bp_taken_out),
        .count_out(count_out), .empty_out(empty_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        disp_valid_in = 1'b0; alu_valid_in = 1'b0; lsu_valid_in = 1'b0;
        st_ready_in = 1'b0; rdy_in = 1'b1; q1_tag_in = '0; q2_tag_in = '0;
        rst_n_in = 1'b0;
        tick();
        rst_n_in = 1'b1;
    endtask

    task automatic alloc(input logic [RA_W-1:0] rd, input logic [XLEN-1:0] pc,
                         input logic br, input logic st, input logic pred);
        disp_valid_in = 1'b1; disp_rd_in = rd; disp_pc_in = pc; disp_fall_pc_in = pc + 4;
        disp_is_br_in = br; disp_is_st_in = st; disp_pred_tk_in = pred;
        tick();
        disp_valid_in = 1'b0;
    endtask

    initial begin
        // Reset state
        rst_n_in = 1'b0;
        tick();
        chk("rst_count", 32'(count_out), 0);
        chk("rst_empty", 32'(empty_out), 1);
        chk("rst_commit_valid", 32'(commit_valid_out), 0);
        chk("rst_flush", 32'(flush_out), 0);
        chk("rst_bp_upd", 32'(bp_upd_out), 0);
        chk("rst_disp_ready", 32'(disp_ready_out), 1);
        chk("rst_disp_tag", 32'(disp_tag_out), 1);
        rst_n_in = 1'b1;

        // Fill to DEPTH, then a fifth alloc must be ignored
        for (int i = 0; i < 4; i++) alloc(5'(i + 1), 32'h40 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        chk("full_count", 32'(count_out), 4);
        chk("full_ready", 32'(disp_ready_out), 0);
        chk("full_tag_wrapped", 32'(disp_tag_out), 1);
        alloc(5'd9, 32'h80, 1'b0, 1'b0, 1'b0);
        chk("full_5th_count", 32'(count_out), 4);
        chk("full_5th_empty", 32'(empty_out), 0);

        // Out-of-order writeback, in-order commit
        do_reset();
        chk("ooo_tag1", 32'(disp_tag_out), 1);
        alloc(5'd1, 32'h10, 1'b0, 1'b0, 1'b0);
        chk("ooo_tag2", 32'(disp_tag_out), 2);
        alloc(5'd2, 32'h14, 1'b0, 1'b0, 1'b0);
        chk("ooo_count2", 32'(count_out), 2);
        alu_valid_in = 1'b1; alu_tag_in = 3'd2; alu_result_in = 32'h55; alu_taken_in = 1'b0;
        tick();
        chk("ooo_no_commit_early", 32'(commit_valid_out), 0);
        alu_tag_in = 3'd1; alu_result_in = 32'h11;
        tick();
        alu_valid_in = 1'b0;
        chk("ooo_wait_latency", 32'(commit_valid_out), 0);
        tick();
        chk("ooo_c1_valid", 32'(commit_valid_out), 1);
        chk("ooo_c1_tag", 32'(commit_tag_out), 1);
        chk("ooo_c1_data", commit_data_out, 32'h11);
        chk("ooo_c1_rd", 32'(commit_rd_out), 1);
        chk("ooo_c1_count", 32'(count_out), 1);
        // Stall holds every output and state
        rdy_in = 1'b0;
        tick();
        chk("stall_valid_held", 32'(commit_valid_out), 1);
        chk("stall_tag_held", 32'(commit_tag_out), 1);
        chk("stall_count_held", 32'(count_out), 1);
        rdy_in = 1'b1;
        tick();
        chk("ooo_c2_tag", 32'(commit_tag_out), 2);
        chk("ooo_c2_data", commit_data_out, 32'h55);
        chk("ooo_c2_rd", 32'(commit_rd_out), 2);
        chk("ooo_c2_empty", 32'(empty_out), 1);
        tick();
        chk("ooo_idle_valid", 32'(commit_valid_out), 0);

        // Alloc while stalled is ignored
        rdy_in = 1'b0;
        alloc(5'd3, 32'h20, 1'b0, 1'b0, 1'b0);
        chk("stall_alloc_count", 32'(count_out), 0);
        rdy_in = 1'b1;

        // Operand lookup and same-cycle bypass
        do_reset();
        for (int i = 0; i < 3; i++) alloc(5'(i + 1), 32'h0, 1'b0, 1'b0, 1'b0);
        q2_tag_in = 3'd3;
        #1;
        chk("opnd_q2_not_ready", 32'(q2_ready_out), 0);
        q1_tag_in = 3'd3;
        alu_valid_in = 1'b1; alu_tag_in = 3'd3; alu_result_in = 32'hAB;
        #1;
        chk("byp_q1_ready", 32'(q1_ready_out), 1);
        chk("byp_q1_data", q1_data_out, 32'hAB);
        chk("byp_q2_data", q2_data_out, 32'hAB);
        tick();
        alu_valid_in = 1'b0;
        #1;
        chk("opnd_stored_ready", 32'(q1_ready_out), 1);
        chk("opnd_stored_data", q1_data_out, 32'hAB);
        q2_tag_in = 3'd0;
        #1;
        chk("opnd_tag0_ready", 32'(q2_ready_out), 0);
        chk("opnd_tag0_data", q2_data_out, 0);
        lsu_valid_in = 1'b1; lsu_tag_in = 3'd2; lsu_result_in = 32'h77; q2_tag_in = 3'd2;
        #1;
        chk("byp_lsu_data", q2_data_out, 32'h77);
        lsu_valid_in = 1'b0;

        // Mispredicted branch: taken but predicted not-taken
        do_reset();
        alloc(5'd0, 32'h100, 1'b1, 1'b0, 1'b0);
        alloc(5'd4, 32'h104, 1'b0, 1'b0, 1'b0);
        alu_valid_in = 1'b1; alu_tag_in = 3'd1; alu_result_in = 32'h0;
        alu_taken_in = 1'b1; alu_target_in = 32'h200;
        tick();
        alu_valid_in = 1'b0;
        chk("br_no_flush_yet", 32'(flush_out), 0);
        tick();
        chk("br_commit_valid", 32'(commit_valid_out), 1);
        chk("br_bp_upd", 32'(bp_upd_out), 1);
        chk("br_bp_pc", bp_pc_out, 32'h100);
        chk("br_bp_taken", 32'(bp_taken_out), 1);
        chk("br_flush", 32'(flush_out), 1);
        chk("br_flush_pc", flush_pc_out, 32'h200);
        chk("br_disp_blocked", 32'(disp_ready_out), 0);
        disp_valid_in = 1'b1;
        tick();
        disp_valid_in = 1'b0;
        chk("br_flush_drop", 32'(flush_out), 0);
        chk("br_count0", 32'(count_out), 0);
        chk("br_empty", 32'(empty_out), 1);
        chk("br_bp_upd_drop", 32'(bp_upd_out), 0);
        chk("br_tail_reset", 32'(disp_tag_out), 1);

        // Store waits for the LSB, commits one cycle after st_ready_in
        do_reset();
        alloc(5'd0, 32'h300, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_wait", 32'(commit_valid_out), 0);
        end
        st_ready_in = 1'b1;
        tick();
        st_ready_in = 1'b0;
        chk("st_commit_valid", 32'(commit_valid_out), 1);
        chk("st_commit_st", 32'(commit_st_out), 1);
        chk("st_commit_tag", 32'(commit_tag_out), 1);
        tick();
        chk("st_one_cycle", 32'(commit_valid_out), 0);

        // Ten alloc/writeback/commit rounds; tags wrap 4 -> 1
        do_reset();
        for (int r = 0; r < 10; r++) begin
            chk("wrap_disp_tag", 32'(disp_tag_out), 32'((r % 4) + 1));
            alloc(5'(r + 1), 32'h0, 1'b0, 1'b0, 1'b0);
            lsu_valid_in = 1'b1; lsu_tag_in = 3'((r % 4) + 1); lsu_result_in = 32'h1000 + 32'(r);
            tick();
            lsu_valid_in = 1'b0;
            tick();
            chk("wrap_commit_tag", 32'(commit_tag_out), 32'((r % 4) + 1));
            chk("wrap_commit_data", commit_data_out, 32'h1000 + 32'(r));
            chk("wrap_count", 32'(count_out), 0);
        end

        // Async reset in the middle of a flush (predicted taken, resolved not-taken)
        do_reset();
        alloc(5'd0, 32'h300, 1'b1, 1'b0, 1'b1);
        alu_valid_in = 1'b1; alu_tag_in = 3'd1; alu_taken_in = 1'b0; alu_target_in = 32'h900;
        tick();
        alu_valid_in = 1'b0;
        tick();
        chk("rf_flush", 32'(flush_out), 1);
        chk("rf_flush_pc_fall", flush_pc_out, 32'h304);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("rf_flush_clr", 32'(flush_out), 0);
        chk("rf_pc_clr", flush_pc_out, 0);
        chk("rf_commit_clr", 32'(commit_valid_out), 0);
        chk("rf_bp_clr", 32'(bp_upd_out), 0);
        chk("rf_empty", 32'(empty_out), 1);
        tick();
        rst_n_in = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
